// File: rtl/focus_peak_tracker_if.sv
// Pixel-stream inputs, stepper context and focus results of the focus peak tracker.
// The sensor/stepper side is the master; the tracker is the slave.
interface focus_peak_tracker_if;
   logic        clr;
   logic        fval;
   logic        lval;
   logic [7:0]  y;
   logic [10:0] step;
   logic        v_c;
   logic [31:0] focus_val;
   logic [31:0] peak_val;
   logic [9:0]  step_up;
   logic [10:0] step_best;
   logic        frame_done;

   modport master (
      output clr, fval, lval, y, step, v_c,
      input  focus_val, peak_val, step_up, step_best, frame_done
   );

   modport slave (
      input  clr, fval, lval, y, step, v_c,
      output focus_val, peak_val, step_up, step_best, frame_done
   );
endinterface

// File: rtl/focus_peak_tracker.sv
// Per-frame windowed sum of thresholded horizontal luma gradients.
// Also tracks the lens step that produced the sharpest frame.
//
// state    | meaning
// S_IDLE   | waiting for FVAL rising edge; step latched and accumulator cleared on entry
// S_ACTIVE | accumulating gradient contributions; leaves when FVAL is sampled low
// S_UPDATE | one cycle: publish the frame sum, update peaks, pulse frame_done
module focus_peak_tracker #(
   parameter logic [10:0] X_START = 11'd320,
   parameter logic [10:0] X_END   = 11'd959,
   parameter logic [10:0] Y_START = 11'd180,
   parameter logic [10:0] Y_END   = 11'd539,
   parameter logic [7:0]  THRESH  = 8'd8
) (
   input logic           clk_i,
   input logic           rst_n_i,
   focus_peak_tracker_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_UPDATE} state_t;

   state_t      state_q;
   logic        fval_q;
   logic        lval_q;
   logic [10:0] x_q;
   logic [10:0] y_q;
   logic [7:0]  y_prev_q;
   logic [10:0] step_lat_q;
   logic [7:0]  contrib_q;
   logic [31:0] acc_q;
   logic [31:0] coarse_q;
   logic [31:0] focus_q;
   logic [31:0] peak_q;
   logic [9:0]  step_up_q;
   logic [10:0] step_best_q;
   logic        done_q;

   logic        pix_vld;
   logic        lval_fall;
   logic [7:0]  diff;
   logic [7:0]  grad;
   logic        in_win;
   logic [7:0]  contrib_d;
   logic [32:0] acc_sum;
   logic [31:0] acc_d;
   logic [9:0]  step_sat;

   always_comb begin
      pix_vld   = (state_q == S_ACTIVE) && bus.fval && bus.lval;
      lval_fall = lval_q && !bus.lval;
      diff      = (bus.y >= y_prev_q) ? (bus.y - y_prev_q) : (y_prev_q - bus.y);
      grad      = (x_q == 11'd0) ? 8'd0 : diff;
      in_win    = (x_q >= X_START) && (x_q <= X_END) && (y_q >= Y_START) && (y_q <= Y_END);
      contrib_d = (pix_vld && in_win && (grad > THRESH)) ? grad : 8'd0;
      acc_sum   = {1'b0, acc_q} + {25'd0, contrib_q};
      acc_d     = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
      step_sat  = (step_lat_q > 11'd1023) ? 10'd1023 : step_lat_q[9:0];
   end

   // fval_q resets high so a frame already in progress at reset release is not taken as a rise
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         fval_q      <= 1'b1;
         lval_q      <= 1'b0;
         x_q         <= 11'd0;
         y_q         <= 11'd0;
         y_prev_q    <= 8'd0;
         step_lat_q  <= 11'd0;
         contrib_q   <= 8'd0;
         acc_q       <= 32'd0;
         coarse_q    <= 32'd0;
         focus_q     <= 32'd0;
         peak_q      <= 32'd0;
         step_up_q   <= 10'd0;
         step_best_q <= 11'd0;
         done_q      <= 1'b0;
      end else begin
         fval_q <= bus.fval;
         lval_q <= bus.lval;
         done_q <= 1'b0;
         if (bus.clr) begin
            state_q     <= S_IDLE;
            contrib_q   <= 8'd0;
            coarse_q    <= 32'd0;
            peak_q      <= 32'd0;
            step_up_q   <= 10'd0;
            step_best_q <= 11'd0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (bus.fval && !fval_q) begin
                     state_q    <= S_ACTIVE;
                     step_lat_q <= bus.step;
                     acc_q      <= 32'd0;
                     contrib_q  <= 8'd0;
                     x_q        <= 11'd0;
                     y_q        <= 11'd0;
                  end
               end
               S_ACTIVE: begin
                  contrib_q <= contrib_d;
                  acc_q     <= acc_d;
                  if (pix_vld) begin
                     y_prev_q <= bus.y;
                     if (x_q != 11'h7FF) x_q <= x_q + 11'd1;
                  end
                  if (lval_fall) begin
                     x_q <= 11'd0;
                     if (y_q != 11'h7FF) y_q <= y_q + 11'd1;
                  end
                  if (!bus.fval) state_q <= S_UPDATE;
               end
               S_UPDATE: begin
                  state_q <= S_IDLE;
                  focus_q <= acc_q;
                  done_q  <= 1'b1;
                  if (acc_q > peak_q) begin
                     peak_q      <= acc_q;
                     step_best_q <= step_lat_q;
                  end
                  if (!bus.v_c && (acc_q > coarse_q)) begin
                     coarse_q  <= acc_q;
                     step_up_q <= step_sat;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.focus_val  = focus_q;
   assign bus.peak_val   = peak_q;
   assign bus.step_up    = step_up_q;
   assign bus.step_best  = step_best_q;
   assign bus.frame_done = done_q;

endmodule

// File: tb/tb_focus_peak_tracker.sv
// Directed bench for focus_peak_tracker on a shrunken 12x5 frame with a 6x3 window.
// Stripe frames give 18 in-window transitions, so the expected sum is 18*amplitude.
module tb_focus_peak_tracker;
   localparam int W = 12;
   localparam int H = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   focus_peak_tracker_if bus();

   focus_peak_tracker #(
      .X_START(11'd3), .X_END(11'd8), .Y_START(11'd1), .Y_END(11'd3), .THRESH(8'd8)
   ) dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit clr_before;
      int base;
      int amp;
      int step;
      bit vc;
      int exp_focus;
      int exp_peak;
      int exp_up;
      int exp_best;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   task automatic start_frame(input int step, input bit vc);
      @(negedge clk);
      bus.step = 11'(step);
      bus.v_c  = vc;
      bus.fval = 1'b1;
      bus.lval = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_line(input int base, input int amp, input int npix, input bit cut);
      for (int x = 0; x < npix; x++) begin
         @(negedge clk);
         bus.lval = 1'b1;
         bus.y    = (x % 2 == 1) ? 8'(base + amp) : 8'(base);
      end
      if (!cut) begin
         @(negedge clk);
         bus.lval = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic full_frame(input int base, input int amp, input int step, input bit vc);
      start_frame(step, vc);
      for (int l = 0; l < H; l++) send_line(base, amp, W, 1'b0);
   endtask

   // Drops FVAL and watches a bounded window for the frame_done pulse.
   task automatic finish_frame(input string nm, input bit expect_done);
      int first;
      int cnt;
      first = 0;
      cnt   = 0;
      @(negedge clk);
      bus.lval = 1'b0;
      bus.fval = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (bus.frame_done) begin
            cnt++;
            if (first == 0) first = i;
         end
      end
      if (expect_done) begin
         chk({nm, " done_latency"}, first, 2);
         chk({nm, " done_width"}, cnt, 1);
      end else begin
         chk({nm, " no_done"}, cnt, 0);
      end
   endtask

   task automatic chk_outs(input string nm, input int f, input int p, input int u, input int b);
      chk({nm, " focus_val"}, bus.focus_val, 32'(f));
      chk({nm, " peak_val"}, bus.peak_val, 32'(p));
      chk({nm, " step_up"}, {22'd0, bus.step_up}, 32'(u));
      chk({nm, " step_best"}, {21'd0, bus.step_best}, 32'(b));
   endtask

   initial begin
      //          clr base amp  step  vc  focus peak  up    best
      vecs[0]  = '{0, 100, 0,   5,    0,  0,    0,    0,    0};
      vecs[1]  = '{0, 0,   50,  40,   0,  900,  900,  40,   40};
      vecs[2]  = '{1, 0,   20,  10,   0,  360,  360,  10,   10};
      vecs[3]  = '{0, 0,   30,  20,   0,  540,  540,  20,   20};
      vecs[4]  = '{0, 0,   30,  30,   0,  540,  540,  20,   20};
      vecs[5]  = '{0, 0,   40,  25,   1,  720,  720,  20,   25};
      vecs[6]  = '{0, 0,   10,  35,   0,  180,  720,  20,   25};
      vecs[7]  = '{1, 0,   8,   7,    0,  0,    0,    0,    0};
      vecs[8]  = '{0, 0,   9,   1200, 0,  162,  162,  1023, 1200};
      vecs[9]  = '{0, 0,   100, 1100, 1,  1800, 1800, 1023, 1100};
      vecs[10] = '{0, 0,   255, 3,    0,  4590, 4590, 3,    3};

      bus.clr = 1'b0; bus.fval = 1'b0; bus.lval = 1'b0;
      bus.y = 8'd0; bus.step = 11'd0; bus.v_c = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk_outs("reset", 0, 0, 0, 0);
      chk("reset frame_done", {31'd0, bus.frame_done}, 0);

      for (int v = 0; v < 11; v++) begin
         if (vecs[v].clr_before) begin
            @(negedge clk); bus.clr = 1'b1;
            @(negedge clk); bus.clr = 1'b0;
         end
         full_frame(vecs[v].base, vecs[v].amp, vecs[v].step, vecs[v].vc);
         finish_frame($sformatf("vec%0d", v), 1'b1);
         chk_outs($sformatf("vec%0d", v), vecs[v].exp_focus, vecs[v].exp_peak,
                  vecs[v].exp_up, vecs[v].exp_best);
      end

      // FVAL drops in the middle of line 2 after pixel x=5: 6*30 + 3*30
      start_frame(50, 1'b0);
      send_line(0, 30, W, 1'b0);
      send_line(0, 30, W, 1'b0);
      send_line(0, 30, 6, 1'b1);
      finish_frame("midline", 1'b1);
      chk_outs("midline", 270, 4590, 3, 3);

      // CLR mid-frame discards the frame and the peaks; focus_val is held
      start_frame(60, 1'b0);
      send_line(0, 40, W, 1'b0);
      send_line(0, 40, W, 1'b0);
      @(negedge clk); bus.clr = 1'b1;
      @(negedge clk); bus.clr = 1'b0;
      for (int l = 2; l < H; l++) send_line(0, 40, W, 1'b0);
      finish_frame("clr_mid", 1'b0);
      chk_outs("clr_mid", 270, 0, 0, 0);

      full_frame(0, 20, 9, 1'b0);
      finish_frame("after_clr", 1'b1);
      chk_outs("after_clr", 360, 360, 9, 9);

      // CLR landing on the UPDATE cycle wins over the update
      full_frame(0, 50, 70, 1'b0);
      @(negedge clk); bus.lval = 1'b0; bus.fval = 1'b0;
      @(negedge clk); bus.clr = 1'b1;
      @(negedge clk); bus.clr = 1'b0;
      begin
         int cnt;
         cnt = {31'd0, bus.frame_done};
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cnt += {31'd0, bus.frame_done};
         end
         chk("clr_update no_done", cnt, 0);
      end
      chk_outs("clr_update", 360, 0, 0, 0);

      full_frame(0, 20, 9, 1'b0);
      finish_frame("rearm", 1'b1);
      chk_outs("rearm", 360, 360, 9, 9);

      // Async reset mid-frame; FVAL still high at release, so the frame is skipped
      start_frame(80, 1'b0);
      send_line(0, 60, W, 1'b0);
      send_line(0, 60, W, 1'b0);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 chk_outs("async_rst", 0, 0, 0, 0);
      chk("async_rst frame_done", {31'd0, bus.frame_done}, 0);
      @(negedge clk); rst_n = 1'b1;
      for (int l = 2; l < H; l++) send_line(0, 60, W, 1'b0);
      finish_frame("rst_skip", 1'b0);
      chk_outs("rst_skip", 0, 0, 0, 0);

      full_frame(0, 30, 12, 1'b0);
      finish_frame("post_rst", 1'b1);
      chk_outs("post_rst", 540, 540, 12, 12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
